id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage directly downstream of the register file. Latches the two RF
//  read operands, the immediate, the register indices and the control word into the
//  EX stage. Detects load-use hazards, inserts one bubble and stalls the front end.
//  Honours downstream stall and branch flush, and counts inserted bubbles.
// PARAMETERS
//  DATA_W   32  operand / immediate width (= `LEN_DATA)
//  REG_W    5   register index width (= `LEN_INST_REG)
//  CTRL_W   8   opaque control word carried ID->EX
//  CNT_W    16  bubble counter width
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       synchronous reset, active-low (0 = reset)
//  id_valid       in   1       ID holds a real instruction
//  id_rs,id_rt    in   REG_W   source indices (same values as RF r1/r2)
//  id_rd          in   REG_W   resolved destination index
//  id_a,id_b      in   DATA_W  RF out1/out2 for id_rs/id_rt
//  id_imm         in   DATA_W  sign/zero-extended immediate
//  id_ctrl        in   CTRL_W  control word
//  id_mem_read    in   1       instruction is a load
//  id_reg_write   in   1       instruction writes a register
//  flush          in   1       kill the ID instruction (taken branch/jump)
//  ex_stall       in   1       EX cannot accept; hold EX contents
//  id_stall       out  1       freeze PC and IF/ID register this cycle
//  ex_valid       out  1       EX holds a real instruction
//  ex_rs,ex_rt,ex_rd out REG_W latched indices
//  ex_a,ex_b,ex_imm  out DATA_W latched operands
//  ex_ctrl        out  CTRL_W  latched control (all-zero when !ex_valid)
//  ex_mem_read,ex_reg_write out 1 latched qualifiers (0 when !ex_valid)
//  bubble_cnt     out  CNT_W   number of load-use bubbles inserted
// BEHAVIOUR
//  - Reset (rst==0 at posedge): every ex_* output, bubble_cnt = 0; id_stall = 0
//    combinationally while rst==0.
//  - load_use = ex_valid & ex_mem_read & id_valid & (ex_rd!=0) &
//    (ex_rd==id_rs | ex_rd==id_rt). Index 0 never hazards.
//  - id_stall = rst & !flush & (ex_stall | load_use); purely combinational, same cycle.
//  - Posedge update priority (highest first):
//    1 rst==0      -> clear as reset.
//    2 flush       -> bubble: ex_valid=0, ex_ctrl=0, ex_mem_read=0, ex_reg_write=0;
//                     data/index fields don't-care (implementation clears them). Wins over ex_stall.
//    3 ex_stall    -> hold all ex_* unchanged; no bubble counted even if load_use.
//    4 load_use    -> bubble as in 2; bubble_cnt += 1.
//    5 otherwise   -> load all ex_* from id_*; ex_valid=id_valid; if !id_valid
//                     the qualifiers and ex_ctrl load as 0.
//  - Latency: 1 cycle ID->EX. A load-use hazard costs exactly one bubble; the cycle
//    after, EX holds the bubble so load_use=0 and the held ID instruction advances.
//  - Back-to-back loads each checked independently; a hazard against a stalled-
//    in-EX load persists until ex_stall drops, then yields one bubble.
//  - bubble_cnt saturates at all-ones; never wraps.
//  - Reset mid-stall: stall and bubble state discarded; first post-reset cycle is RUN.
// CONFIGURATION
//  ID_EX_MEM_BYPASS_EN (defined): extra inputs mem_reg_write(1), mem_rd(REG_W),
//    mem_data(DATA_W). On a normal load (priority 5), if mem_reg_write & mem_rd!=0 &
//    mem_rd==id_rs then ex_a<=mem_data (likewise id_rt -> ex_b); both may match.
//  Undefined: ports absent; ex_a/ex_b always load id_a/id_b.
// TESTING
//  1 rst=0 for 2 cycles with id_valid=1 -> all ex_* =0, bubble_cnt=0, id_stall=0.
//  2 id: add rs=1,rt=2,rd=3,a=5,b=7 -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_rd=3.
//  3 EX=lw rd=4; ID uses rs=4 -> id_stall=1 for 1 cycle, EX bubble, bubble_cnt=1,
//    then instruction enters EX; EX=lw rd=0 with rs=0 -> no stall.
//  4 flush=1 while ex_stall=1 and load_use -> ex_valid=0, id_stall=0, cnt unchanged.
//  5 ex_stall=1 for 3 cycles -> ex_* unchanged, id_stall=1 each cycle.
//  6 BYPASS_EN: mem_rd=1, mem_data=0xDEAD, id_rs=id_rt=1 -> ex_a=ex_b=0xDEAD;
//    force bubble_cnt to all-ones, another hazard -> stays all-ones.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches RF operands, immediate, indices and control into EX; detects load-use hazards.
// Latency: 1 cycle ID->EX; a load-use hazard costs exactly one bubble (counted, saturating).
// Backpressure: ex_stall holds EX and raises id_stall; flush kills the ID instruction and overrides ex_stall.
// Optional feature: define ID_EX_MEM_BYPASS_EN to add the MEM-stage forwarding inputs for ex_a/ex_b.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              ex_stall,
`ifdef ID_EX_MEM_BYPASS_EN
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_data,
`endif
    output logic              id_stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_ex_valid;
    logic [REG_W-1:0]  r_ex_rs;
    logic [REG_W-1:0]  r_ex_rt;
    logic [REG_W-1:0]  r_ex_rd;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [DATA_W-1:0] r_ex_imm;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic              r_ex_mem_read;
    logic              r_ex_reg_write;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_load_use;
    logic              w_kill;
    logic              w_cnt_sat;
    logic [DATA_W-1:0] w_a_next;
    logic [DATA_W-1:0] w_b_next;

    // A load in EX whose destination feeds the ID instruction; register 0 never hazards.
    assign w_load_use = r_ex_valid & r_ex_mem_read & id_valid & (r_ex_rd != '0) &
                        ((r_ex_rd == id_rs) | (r_ex_rd == id_rt));

    // Front-end freeze; a flush discards the ID instruction so there is nothing to hold.
    assign id_stall = rst & ~flush & (ex_stall | w_load_use);

    // Bubble into EX on flush, or on a hazard when EX is free to advance.
    assign w_kill = flush | (~ex_stall & w_load_use);

    assign w_cnt_sat = &r_bubble_cnt;

`ifdef ID_EX_MEM_BYPASS_EN
    // Forward the MEM-stage result over the stale RF read when indices match.
    assign w_a_next = (mem_reg_write && (mem_rd != '0) && (mem_rd == id_rs)) ? mem_data : id_a;
    assign w_b_next = (mem_reg_write && (mem_rd != '0) && (mem_rd == id_rt)) ? mem_data : id_b;
`else
    assign w_a_next = id_a;
    assign w_b_next = id_b;
`endif

    // EX register: reset/bubble clears, stall holds, otherwise load from ID.
    always_ff @(posedge clk) begin
        if (!rst || w_kill) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_rd        <= '0;
            r_ex_a         <= '0;
            r_ex_b         <= '0;
            r_ex_imm       <= '0;
            r_ex_ctrl      <= '0;
            r_ex_mem_read  <= 1'b0;
            r_ex_reg_write <= 1'b0;
        end else if (!ex_stall) begin
            r_ex_valid     <= id_valid;
            r_ex_rs        <= id_rs;
            r_ex_rt        <= id_rt;
            r_ex_rd        <= id_rd;
            r_ex_a         <= w_a_next;
            r_ex_b         <= w_b_next;
            r_ex_imm       <= id_imm;
            r_ex_ctrl      <= id_valid ? id_ctrl : '0;
            r_ex_mem_read  <= id_valid & id_mem_read;
            r_ex_reg_write <= id_valid & id_reg_write;
        end
    end

    // Count load-use bubbles only when they are actually inserted; saturate at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (!flush && !ex_stall && w_load_use && !w_cnt_sat) begin
            r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign ex_rd        = r_ex_rd;
    assign ex_a         = r_ex_a;
    assign ex_b         = r_ex_b;
    assign ex_imm       = r_ex_imm;
    assign ex_ctrl      = r_ex_ctrl;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_reg_write = r_ex_reg_write;
    assign bubble_cnt   = r_bubble_cnt;

endmodule
